uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 115200, line baud rate.
REQ-003 The block SHALL have port clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-005 The block SHALL have port uart_rxd, input, 1 bit, asynchronous serial line; idles high.
REQ-006 The block SHALL have port rx_done, output, 1 bit, one-cycle pulse when a valid byte is on rx_data.
REQ-007 The block SHALL have port rx_data, output, 8 bits, last correctly framed byte, held until the next valid byte.
REQ-008 The block SHALL have port frame_err, output, 1 bit, one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port rx_busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL define BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division) and HALF = BAUD_CNT_MAX/2.
REQ-011 The block SHALL synchronise uart_rxd through two flip-flops (rxd_s) plus one delay flip-flop (rxd_d), all resetting to 1.
REQ-012 The block SHALL detect a start edge when rxd_d==1 and rxd_s==0 in state IDLE.
REQ-013 The state machine SHALL have states IDLE, START, DATA and STOP; encoding is binary, 2 bits.
REQ-014 The baud counter SHALL hold at 0 in IDLE and otherwise count 0..BAUD_CNT_MAX-1, wrapping to 0.
REQ-015 The bit counter SHALL advance only at a baud-counter wrap.
REQ-016 IDLE SHALL go to START on a start edge, with the baud counter at 0.
REQ-017 START SHALL sample rxd_s when the baud counter equals HALF; if the sample is 1 (glitch), the block SHALL return to IDLE with no output pulse.
REQ-018 START SHALL go to DATA at the baud-counter wrap, with the bit counter at 0.
REQ-019 DATA SHALL shift rxd_s into an 8-bit shift register LSB-first when the baud counter equals HALF.
REQ-020 DATA SHALL go to STOP at the wrap following bit 7.
REQ-021 In STOP, when the baud counter equals HALF: if rxd_s==1, the block SHALL load rx_data from the shift register and pulse rx_done for exactly one cycle; if rxd_s==0, it SHALL pulse frame_err for one cycle and leave rx_data unchanged.
REQ-022 In both stop-bit cases the block SHALL return to IDLE at the stop sample, not at the end of the bit, so a start bit arriving back-to-back is captured.
REQ-023 rx_done SHALL rise exactly 9*BAUD_CNT_MAX+HALF+1 clk cycles after the first cycle in START.
REQ-024 rx_done and frame_err SHALL never be high in the same cycle.
REQ-025 A line held low after a frame error SHALL NOT retrigger; a new frame SHALL require a fresh high-to-low edge.
REQ-026 The shift register SHALL NOT be cleared between frames; it is fully overwritten by 8 samples.

Reset
REQ-027 On rst, the block SHALL force state IDLE, both counters 0, shift register 0, rx_data 0x00, rx_done 0, frame_err 0 and rx_busy 0.
REQ-028 On rst, the synchroniser flip-flops SHALL reset to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-030 After reset releases, the block SHALL resume edge search with the line low treated as no edge.

Structure
REQ-031 State encodings and the BAUD_CNT_MAX/HALF formulas SHALL live in shared header uart_defs.vh, used by both the RX and TX blocks.
REQ-032 The two-flip-flop synchroniser SHALL be sub-module uart_sync2 (reset value parameterised, default 1); everything else SHALL be flat in uart_rx.
REQ-033 The baud counter SHALL be 17 bits wide, sufficient for BAUD_CNT_MAX up to 131071.

Verification
REQ-034 With defaults (BAUD_CNT_MAX=434, HALF=217), the bench SHALL drive 8N1 0x55 at 434 clk/bit -> rx_data=0x55, rx_done exactly one cycle, frame_err never set.
REQ-035 The bench SHALL drive back-to-back 0xA3, 0x00, 0xFF with no idle gap -> three rx_done pulses with the values in order, 434*10 cycles apart.
REQ-036 The bench SHALL drive a 100-cycle low glitch -> no rx_done, no frame_err, rx_busy drops within 220 cycles.
REQ-037 The bench SHALL drive 0x3C with the stop bit low, after a prior 0x12 -> frame_err pulses once, rx_data stays 0x12; the line then held low 2000 cycles -> no further activity.
REQ-038 The bench SHALL assert rst for 1 cycle during bit 3 of 0x99, then send 0x81 -> no pulse for 0x99, rx_data=0x81 with one rx_done.
REQ-039 The bench SHALL run with baud off by ±2% (426/443 clk/bit) sending 0xC7 -> rx_data=0xC7, no frame_err.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and baud-timing helpers.
// Both receiver and transmitter blocks import this package.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int BAUD_CNT_W = 17;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int baud_half(input int clk_freq, input int bps);
        return baud_cnt_max(clk_freq, bps) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is configurable so an idle-high line looks idle out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, frame-error detection, and early
// return to IDLE at the stop sample so back-to-back frames are caught.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_CNT_MAX = BAUD_CNT_W'(baud_cnt_max(CLK_FREQ, UART_BPS));
    localparam logic [BAUD_CNT_W-1:0] HALF         = BAUD_CNT_W'(baud_half(CLK_FREQ, UART_BPS));
    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST    = BAUD_CNT_MAX - BAUD_CNT_W'(1);

    uart_state_e           state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            data_q, data_d;
    logic                  done_q, done_d;
    logic                  fe_q, fe_d;
    logic                  rxd_s, rxd_d_q;
    logic [1:0]            arm_q;
    logic                  start_edge, baud_wrap, at_half;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rxd),
        .q_o (rxd_s)
    );

    // Edge search waits until the synchroniser and delay flop hold real line
    // samples, so a line already low when reset releases is not an edge.
    assign start_edge = (arm_q == 2'd3) && rxd_d_q && !rxd_s;
    assign baud_wrap  = (baud_q == BAUD_LAST);
    assign at_half    = (baud_q == HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            rxd_d_q <= 1'b1;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            rxd_d_q <= rxd_s;
            if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (at_half && rxd_s) begin
                    state_d = IDLE;
                end else if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_half) shift_d = {rxd_s, shift_q[7:1]};
                if (baud_wrap) begin
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (at_half) begin
                    state_d = IDLE;
                    if (rxd_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counter restarts at 0 on every entry to START.
        if (state_q == IDLE || state_d == IDLE) baud_d = '0;
        else if (baud_wrap)                     baud_d = '0;
        else                                    baud_d = baud_q + BAUD_CNT_W'(1);
    end

    assign rx_done   = done_q;
    assign rx_data   = data_q;
    assign frame_err = fe_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
